// File: rtl/fabric_mem_load_port.sv
// Memory-side responder for load PEs: turns tagged address requests into 1-cycle SRAM reads
// and returns in-order, credit-limited responses with sticky out-of-range reporting.
module fabric_mem_load_port #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 0,
  parameter int ADDR_WIDTH = 10,
  parameter int RESP_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [DATA_WIDTH+TAG_WIDTH-1:0] req_data,
  output logic                            mem_rd_en,
  output logic [ADDR_WIDTH-1:0]           mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]           mem_rd_data,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0] resp_data,
  output logic                            err_oob,
  output logic [DATA_WIDTH-1:0]           err_addr
);

  localparam int ENTRY_W = DATA_WIDTH + TAG_WIDTH;
  localparam int PTR_W   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W   = $clog2(RESP_DEPTH + 1);

  generate
    if (DATA_WIDTH < 1) begin : g_bad_data_width
      $fatal(1, "fabric_mem_load_port: DATA_WIDTH must be >= 1");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > DATA_WIDTH) begin : g_bad_addr_width
      $fatal(1, "fabric_mem_load_port: ADDR_WIDTH must be in 1..DATA_WIDTH");
    end
    if (RESP_DEPTH < 2) begin : g_bad_resp_depth
      $fatal(1, "fabric_mem_load_port: RESP_DEPTH must be >= 2");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] req_addr;
  logic                  req_oob;
  logic                  fire;
  logic                  pop;

  logic                  pend_valid_reg;
  logic                  pend_oob_reg;
  logic [DATA_WIDTH-1:0] push_data;
  logic [ENTRY_W-1:0]    push_entry;

  logic [ENTRY_W-1:0]    fifo_mem [RESP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic [CNT_W:0]        occ;

  logic                  err_oob_reg;
  logic [DATA_WIDTH-1:0] err_addr_reg;

  assign req_addr = req_data[DATA_WIDTH-1:0];

  generate
    if (ADDR_WIDTH < DATA_WIDTH) begin : g_range_check
      assign req_oob = |req_addr[DATA_WIDTH-1:ADDR_WIDTH];
    end else begin : g_full_range
      assign req_oob = 1'b0;
    end
  endgenerate

  // Credits count reads already in the SRAM pipe so a capture never finds the FIFO full.
  assign occ       = {1'b0, count_reg} + {{CNT_W{1'b0}}, pend_valid_reg};
  assign req_ready = !rst && (occ < (CNT_W + 1)'(RESP_DEPTH));
  assign fire      = req_valid && req_ready;

  assign mem_rd_en   = fire && !req_oob;
  assign mem_rd_addr = req_addr[ADDR_WIDTH-1:0];

  assign resp_valid = !rst && (count_reg != '0);
  assign resp_data  = fifo_mem[rd_ptr_reg];
  assign pop        = resp_valid && resp_ready;

  // Out-of-range requests never touch the SRAM; their slot carries zero data.
  assign push_data = pend_oob_reg ? '0 : mem_rd_data;

  generate
    if (TAG_WIDTH > 0) begin : g_tag
      logic [TAG_WIDTH-1:0] pend_tag_reg;

      always_ff @(posedge clk) begin
        if (fire) begin
          pend_tag_reg <= req_data[ENTRY_W-1:DATA_WIDTH];
        end
      end

      assign push_entry = {pend_tag_reg, push_data};
    end else begin : g_no_tag
      assign push_entry = push_data;
    end
  endgenerate

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    count_next = count_reg;
    if (pend_valid_reg && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!pend_valid_reg && pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (pend_valid_reg) begin
      fifo_mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_reg <= 1'b0;
      pend_oob_reg   <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      err_oob_reg    <= 1'b0;
      err_addr_reg   <= '0;
    end else begin
      pend_valid_reg <= fire;
      pend_oob_reg   <= fire && req_oob;
      count_reg      <= count_next;
      if (pend_valid_reg) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      // Only the first offending address is kept for post-mortem.
      if (fire && req_oob && !err_oob_reg) begin
        err_oob_reg  <= 1'b1;
        err_addr_reg <= req_addr;
      end
    end
  end

  assign err_oob  = err_oob_reg;
  assign err_addr = err_addr_reg;

endmodule
